// File: rtl/exc_controller_pkg.sv
// Shared types and constants for the exception controller.
// States, event codes, PSR cause codes and the default interrupt-enable bit.
package exc_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef enum logic [2:0] {EV_NONE, EV_ILL, EV_TRAP, EV_IRQ, EV_RFI} event_t;

  // Cause codes the control registers load into the PSR for each event class
  localparam logic [3:0] CAUSE_ILL  = 4'b0011;
  localparam logic [3:0] CAUSE_TRAP = 4'b0101;
  localparam logic [3:0] CAUSE_IRQ  = 4'b1001;

  localparam int IE_BIT_DFLT = 4;

endpackage

// File: rtl/exc_controller_irq_pending.sv
// IRQ pending collector and lowest-index priority encoder.
// EXC_IRQ_EDGE_EN: pending bits latch on a 0->1 edge of irq and hold until
// acked; otherwise pending simply follows the irq levels.
// clr is the registered ack vector, so a bit drops in its ack cycle.
module irq_pending #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = $clog2(N_IRQ)
) (
`ifdef EXC_IRQ_EDGE_EN
  input  logic             clk,
  input  logic             rst,
`endif
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] clr,
  output logic             vld,
  output logic [ID_W-1:0]  idx
);

  logic [N_IRQ-1:0] pending;

`ifdef EXC_IRQ_EDGE_EN
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pend_q;

  // A rising edge in the current cycle counts immediately so acceptance
  // latency matches the level-sensitive build.
  assign pending = (pend_q | (irq & ~irq_q)) & ~clr;

  // Track previous irq levels and hold latched requests until acked
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq;
      pend_q <= pending;
    end
  end
`else
  assign pending = irq & ~clr;
`endif

  // Lowest set index wins
  always_comb begin
    idx = '0;
    for (int i = N_IRQ-1; i >= 0; i--)
      if (pending[i]) idx = ID_W'(i);
    vld = |pending;
  end

endmodule

// File: rtl/exc_controller.sv
// Exception sequencer for the 16-bit core: arbitrates illegal/trap/IRQ/rfi
// at instruction boundaries, emits one registered event pulse, then holds
// flush for DRAIN_CYCLES more cycles before accepting again.
// Optional: EXC_IRQ_EDGE_EN selects edge-latched IRQ pending bits.
module exc_controller
  import exc_ctrl_pkg::*;
#(
  parameter int N_IRQ        = 4,
  parameter int ID_W         = $clog2(N_IRQ),
  parameter int DRAIN_CYCLES = 2,
  parameter int IE_BIT       = IE_BIT_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic             ill_req,
  input  logic             trap_req,
  input  logic             rfi_req,
  input  logic [N_IRQ-1:0] irq,
  input  logic [15:0]      psr_in,
  output logic             ill_inst,
  output logic             trap,
  output logic             ir,
  output logic             rfi,
  output logic             flush,
  output logic             busy,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_IRQ-1:0] irq_ack
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 2);

  state_t            state;
  event_t            ev;
  logic [CNT_W-1:0]  cnt;
  logic              irq_en;
  logic              p_vld;
  logic [ID_W-1:0]   p_idx;

  irq_pending #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_pend (
`ifdef EXC_IRQ_EDGE_EN
    .clk (clk),
    .rst (rst),
`endif
    .irq (irq),
    .clr (irq_ack),
    .vld (p_vld),
    .idx (p_idx)
  );

  // Bit 0 of the PSR marks "inside a handler": no nesting of interrupts
  assign irq_en = psr_in[IE_BIT] & ~psr_in[0];

  // Fixed-priority pick of the event offered this cycle
  always_comb begin
    ev = EV_NONE;
    if (inst_valid) begin
      if (ill_req)             ev = EV_ILL;
      else if (trap_req)       ev = EV_TRAP;
      else if (irq_en && p_vld) ev = EV_IRQ;
      else if (rfi_req)        ev = EV_RFI;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ill_inst <= 1'b0;
      trap     <= 1'b0;
      ir       <= 1'b0;
      rfi      <= 1'b0;
      flush    <= 1'b0;
      busy     <= 1'b0;
      irq_id   <= '0;
      irq_ack  <= '0;
    end else begin
      ill_inst <= 1'b0;
      trap     <= 1'b0;
      ir       <= 1'b0;
      rfi      <= 1'b0;
      irq_ack  <= '0;
      case (state)
        IDLE: begin
          if (ev != EV_NONE) begin
            state    <= ISSUE;
            flush    <= 1'b1;
            busy     <= 1'b1;
            ill_inst <= (ev == EV_ILL);
            trap     <= (ev == EV_TRAP);
            ir       <= (ev == EV_IRQ);
            rfi      <= (ev == EV_RFI);
            if (ev == EV_IRQ) begin
              irq_ack <= N_IRQ'(1) << p_idx;
              irq_id  <= p_idx;
            end
          end
        end
        ISSUE: begin
          if (DRAIN_CYCLES > 0) begin
            state <= DRAIN;
            cnt   <= CNT_W'(DRAIN_CYCLES - 1);
          end else begin
            state <= IDLE;
            flush <= 1'b0;
            busy  <= 1'b0;
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            state <= IDLE;
            flush <= 1'b0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_controller.sv
// Directed bench for exc_controller: a table of single-event vectors, each
// run from a fresh reset, plus hand-written multi-cycle sequences.
module tb_exc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       inst_valid, ill_req, trap_req, rfi_req;
  logic [3:0] irq;
  logic [15:0] psr_in;
  logic       ill_inst, trap, ir, rfi, flush, busy;
  logic [1:0] irq_id;
  logic [3:0] irq_ack;

  int total = 0;
  int bad   = 0;

  exc_controller dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .ill_req(ill_req),
    .trap_req(trap_req), .rfi_req(rfi_req), .irq(irq), .psr_in(psr_in),
    .ill_inst(ill_inst), .trap(trap), .ir(ir), .rfi(rfi), .flush(flush),
    .busy(busy), .irq_id(irq_id), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv, ill, trp, rf;
    logic [3:0] irq;
    logic [15:0] psr;
    logic [3:0] ex_pulse;  // {ill_inst, trap, ir, rfi}
    logic [3:0] ex_ack;
    logic [1:0] ex_id;
  } vec_t;

  vec_t tbl[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    inst_valid = 0; ill_req = 0; trap_req = 0; rfi_req = 0;
    irq = '0; psr_in = '0;
  endtask

  task automatic rst_dut();
    clr_in();
    rst = 0;
    step();
    step();
    rst = 1;
  endtask

  function automatic logic [3:0] pulses();
    return {ill_inst, trap, ir, rfi};
  endfunction

  logic [3:0] ack_acc;

  initial begin
    tbl[0] = '{1, 1, 1, 0, 4'b0010, 16'h0010, 4'b1000, 4'b0000, 2'd0};
    tbl[1] = '{1, 0, 1, 1, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 2'd0};
    tbl[2] = '{1, 0, 0, 0, 4'b1010, 16'h0010, 4'b0010, 4'b0010, 2'd1};
    tbl[3] = '{1, 0, 0, 1, 4'b0001, 16'h0011, 4'b0001, 4'b0000, 2'd0};
    tbl[4] = '{0, 1, 0, 0, 4'b0001, 16'h0010, 4'b0000, 4'b0000, 2'd0};
    tbl[5] = '{1, 0, 0, 0, 4'b0100, 16'h0000, 4'b0000, 4'b0000, 2'd0};
    tbl[6] = '{1, 0, 0, 1, 4'b1000, 16'h0010, 4'b0010, 4'b1000, 2'd3};
    tbl[7] = '{1, 0, 0, 1, 4'b0000, 16'h0000, 4'b0001, 4'b0000, 2'd0};
    tbl[8] = '{1, 0, 0, 0, 4'b0110, 16'hFFFE, 4'b0010, 4'b0010, 2'd1};

    // Reset state held with idle inputs
    rst_dut();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_idle", {pulses(), flush, busy, irq_id, irq_ack}, 32'h0);
    end

    // Table: one event from reset, check issue cycle, drain and return
    for (int v = 0; v < 9; v++) begin
      rst_dut();
      inst_valid = tbl[v].iv; ill_req = tbl[v].ill; trap_req = tbl[v].trp;
      rfi_req = tbl[v].rf; irq = tbl[v].irq; psr_in = tbl[v].psr;
      step();
      chk($sformatf("v%0d_pulse", v), pulses(), tbl[v].ex_pulse);
      chk($sformatf("v%0d_ack", v), irq_ack, tbl[v].ex_ack);
      chk($sformatf("v%0d_id", v), irq_id, tbl[v].ex_id);
      chk($sformatf("v%0d_flush", v), flush, |tbl[v].ex_pulse);
      chk($sformatf("v%0d_busy", v), busy, |tbl[v].ex_pulse);
      clr_in();
      step();
      chk($sformatf("v%0d_t2", v), {pulses(), irq_ack, flush},
          {8'h00, |tbl[v].ex_pulse});
      step();
      step();
      chk($sformatf("v%0d_t4_idle", v), {flush, busy}, 2'b00);
    end

    // Illegal beats trap and a pending IRQ; the IRQ survives the drain
    rst_dut();
    inst_valid = 1; ill_req = 1; trap_req = 1; irq = 4'b0010; psr_in = 16'h0010;
    step();
    chk("s2_ill", pulses(), 4'b1000);
    ack_acc = irq_ack;
    inst_valid = 0; ill_req = 0; trap_req = 0;
    step();
    chk("s2_t2_pulse", pulses(), 4'b0000);
    ack_acc |= irq_ack;
    step();
    chk("s2_t3_flush", flush, 1'b1);
    ack_acc |= irq_ack;
    step();
    chk("s2_t4_idle", {flush, busy}, 2'b00);
    ack_acc |= irq_ack;
    chk("s2_no_ack", ack_acc, 4'b0000);
    // Lowest index of 1010 is taken first; line 1 then dropped by its source
    inst_valid = 1; irq = 4'b1010;
    step();
    chk("s3_ir", pulses(), 4'b0010);
    chk("s3_ack1", irq_ack, 4'b0010);
    chk("s3_id1", irq_id, 2'd1);
    inst_valid = 0; irq = 4'b1000;
    step(); step(); step();
    chk("s3_id_held", irq_id, 2'd1);
    chk("s3_idle", busy, 1'b0);
    inst_valid = 1;
    step();
    chk("s3_ack3", irq_ack, 4'b1000);
    chk("s3_id3", irq_id, 2'd3);
    chk("s3_ir2", ir, 1'b1);
    clr_in();
    step(); step(); step();

    // In-handler masks IRQ so rfi is taken; IRQ follows once unmasked
    rst_dut();
    inst_valid = 1; rfi_req = 1; irq = 4'b0001; psr_in = 16'h0011;
    step();
    chk("s4_rfi", pulses(), 4'b0001);
    chk("s4_noack", irq_ack, 4'b0000);
    inst_valid = 0; rfi_req = 0;
    step(); step(); step();
    inst_valid = 1; psr_in = 16'h0010;
    step();
    chk("s4_ir", pulses(), 4'b0010);
    chk("s4_id0", irq_id, 2'd0);
    chk("s4_ack0", irq_ack, 4'b0001);
    clr_in();
    step(); step(); step();

    // Reset during drain, then a normal trap
    rst_dut();
    inst_valid = 1; trap_req = 1;
    step();
    chk("s5_trap", pulses(), 4'b0100);
    inst_valid = 0; trap_req = 0;
    step();
    chk("s5_drain_busy", busy, 1'b1);
    rst = 0;
    step();
    rst = 1;
    chk("s5_after_rst", {pulses(), flush, busy, irq_ack}, 10'h0);
    inst_valid = 1; trap_req = 1;
    step();
    chk("s5_trap2", pulses(), 4'b0100);
    chk("s5_flush2", flush, 1'b1);
    clr_in();
    step(); step(); step();

    // Short irq[2] pulse while busy
    rst_dut();
    inst_valid = 1; trap_req = 1;
    step();
    inst_valid = 0; trap_req = 0; irq = 4'b0100;
    step();
    irq = 4'b0000;
    step(); step();
    chk("s6_idle", busy, 1'b0);
    inst_valid = 1; psr_in = 16'h0010;
    step();
`ifdef EXC_IRQ_EDGE_EN
    chk("s6_ir", ir, 1'b1);
    chk("s6_id2", irq_id, 2'd2);
    chk("s6_ack2", irq_ack, 4'b0100);
`else
    chk("s6_no_ir", ir, 1'b0);
    chk("s6_id0", irq_id, 2'd0);
    chk("s6_no_ack", irq_ack, 4'b0000);
`endif
    clr_in();
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exc_controller.md
Name: exc_controller

Overview:
- Sequences the control-register file's exception inputs (ill_inst, trap, ir, rfi) for the 16-bit core.
- Collects synchronous exception requests from decode and asynchronous-source IRQ lines, then applies PSR-based masking and fixed priority.
- Issues exactly one single-cycle event pulse per accepted event, followed by a pipeline flush/drain window.
- Sits between decode/interrupt sources and the control registers.

Parameters:
- N_IRQ, 4, number of external interrupt lines; index 0 has highest priority.
- ID_W, $clog2(N_IRQ), width of irq_id.
- DRAIN_CYCLES, 2, flush cycles after the issue cycle; 0 is legal.
- IE_BIT, 4, PSR bit index of the global interrupt enable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset; reset is applied when rst==0 at a clock edge.
- inst_valid  in  1  decode holds a valid instruction at an issue boundary.
- ill_req  in  1  decoded instruction is illegal (qualified by inst_valid).
- trap_req  in  1  decoded instruction is a trap (qualified by inst_valid).
- rfi_req  in  1  decoded instruction is rfi (qualified by inst_valid).
- irq  in  N_IRQ  interrupt request lines, already synchronous to clk.
- psr_in  in  16  current PSR value from the control registers.
- ill_inst  out  1  one-cycle pulse to the control registers.
- trap  out  1  one-cycle pulse.
- ir  out  1  one-cycle pulse.
- rfi  out  1  one-cycle pulse.
- flush  out  1  kill/stall the front-end pipeline.
- busy  out  1  high whenever state != IDLE.
- irq_id  out  ID_W  index of the last taken IRQ; held until the next IRQ is taken.
- irq_ack  out  N_IRQ  one-hot pulse in the issue cycle of a taken IRQ.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - All pulse outputs, flush, busy, irq_ack = 0.
  - irq_id = 0.
  - pending = 0.
  - Drain counter = 0.
- States:
  - IDLE: accept events.
  - ISSUE: one cycle, pulse active.
  - DRAIN: DRAIN_CYCLES cycles.
- Interrupt eligibility: irq_en = psr_in[IE_BIT] & ~psr_in[0] (bit0 = in-handler flag).
- Pending: pending[i] follows irq[i] (level) or the latched edge (see Optional Feature). pending[i] clears in the cycle irq_ack[i] is asserted.
- Acceptance occurs in IDLE at cycle T when inst_valid==1 and any event is present. Priority, highest first:
  1. ill_req
  2. trap_req
  3. IRQ (pending != 0 and irq_en)
  4. rfi_req
- At T+1: state=ISSUE, exactly one pulse high, flush=1, busy=1.
- For an IRQ: the lowest set pending index k is selected; irq_ack[k]=1 and irq_id=k, both registered at T+1.
- Requests of lower priority present at T are dropped. Synchronous requests are re-raised by decode after the flush; IRQs remain pending.
- ISSUE -> DRAIN when DRAIN_CYCLES>0, else ISSUE -> IDLE. DRAIN lasts exactly DRAIN_CYCLES cycles with flush=1, then returns to IDLE.
- Outside IDLE: all requests are ignored, and pending continues to collect new IRQs.
- inst_valid==0 in IDLE: nothing is accepted and no pulses are issued.
- irq_en==0: IRQs stay pending indefinitely; synchronous requests are still served.
- Reset asserted in ISSUE or DRAIN: IDLE at the next edge, all outputs cleared, pending cleared.
- Minimum spacing between two pulses is 2+DRAIN_CYCLES cycles.

Optional Feature:
- Macro: EXC_IRQ_EDGE_EN.
- Defined: pending[i] is set on a 0->1 transition of irq[i], using a registered copy of irq. It stays set after irq drops, until acked.
- Undefined: pending = irq (level-sensitive). An irq deasserted before acceptance is lost. irq_ack is still driven for the source to clear its line.

Decomposition:
- Package exc_ctrl_pkg holds:
  - State enum: IDLE, ISSUE, DRAIN.
  - Event enum: EV_NONE, EV_ILL, EV_TRAP, EV_IRQ, EV_RFI.
  - PSR cause constants: 4'b0011, 4'b0101, 4'b1001.
  - IE_BIT default.
- Sub-module irq_pending: pending latch (edge/level), lowest-index priority encoder, valid/index outputs, clear-by-ack input.

Test Plan:
1. Release rst (0->1), hold inputs 0 for 5 cycles -> all outputs 0, busy=0.
2. inst_valid=1, ill_req=1, trap_req=1, irq=4'b0010, psr_in=16'h0010 at T -> ill_inst=1 at T+1 only; flush=1 for T+1..T+3; busy=0 at T+4; irq_ack stays 0 and pending[1] stays 1.
3. psr_in=16'h0010, irq=4'b1010, inst_valid=1 -> ir=1 and irq_ack=4'b0010 at T+1, irq_id=1. After drain, with psr_in=16'h0010, the next acceptance gives irq_ack=4'b1000 and irq_id=3.
4. psr_in=16'h0011 (in-handler), irq=4'b0001, rfi_req=1 -> rfi pulse only. Then psr_in=16'h0010 -> ir taken with irq_id=0.
5. In DRAIN, drive rst=0 for one edge -> next cycle flush=0, busy=0, pending=0; a trap_req afterwards is accepted normally.
6. EXC_IRQ_EDGE_EN defined: irq[2] pulses high for 1 cycle while busy=1 -> after IDLE, with inst_valid=1 and psr_in=16'h0010, ir fires with irq_id=2. Undefined: same stimulus produces no ir.
